// File: rtl/out_fifo_if.sv
// Handshake bundle of the USB full-speed OUT FIFO: SIE receive side and application stream side.
// The slave modport is the FIFO's view; the master modport is the SIE/application view.
interface out_fifo_if;
    logic [7:0] app_out_data_o;
    logic       app_out_valid_o;
    logic       app_out_ready_i;
    logic       out_empty_o;
    logic       out_full_o;
    logic       out_nak_o;
    logic       out_req_i;
    logic [7:0] out_data_i;
    logic       out_valid_i;
    logic       out_ready_i;
    logic       out_err_i;

    modport slave (
        output app_out_data_o, app_out_valid_o, out_empty_o, out_full_o, out_nak_o,
        input  app_out_ready_i, out_req_i, out_data_i, out_valid_i, out_ready_i, out_err_i
    );

    modport master (
        input  app_out_data_o, app_out_valid_o, out_empty_o, out_full_o, out_nak_o,
        output app_out_ready_i, out_req_i, out_data_i, out_valid_i, out_ready_i, out_err_i
    );
endinterface

// File: rtl/out_fifo_mem.sv
// Byte storage for the OUT FIFO: one synchronous write port, one asynchronous read port.
// Contents are cleared by reset so the read port shows 0 on an empty, freshly reset buffer.
module out_fifo_mem #(
    parameter int DEPTH = 17,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) mem_d[waddr_i] = wdata_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/out_fifo.sv
// USB 2.0 full-speed OUT FIFO: the SIE writes a tentative packet region that is committed on a
// good end of packet or rolled back on error; the application drains committed bytes, paced.
module out_fifo #(
    parameter int OUT_MAXPACKETSIZE = 8,
    parameter int BIT_SAMPLES       = 4
) (
    input logic       clk_i,
    input logic       rstn_i,
    out_fifo_if.slave bus
);
    function automatic int ceil_log2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    localparam int OUT_LENGTH = 2 * OUT_MAXPACKETSIZE + 1;
    localparam int AW         = ceil_log2(OUT_LENGTH);
    localparam int PW         = (BIT_SAMPLES > 1) ? ceil_log2(BIT_SAMPLES) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(OUT_LENGTH - 1);
    localparam logic [PW-1:0] PACE_MAX = PW'(BIT_SAMPLES - 1);

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + AW'(1);
    endfunction

    logic [AW-1:0] out_first_q, out_first_d;
    logic [AW-1:0] out_last_q, out_last_d;
    logic [AW-1:0] out_last_qq, out_last_qd;
    logic          ovf_q, ovf_d;
    logic          req_q, req_d;
    logic [PW-1:0] pace_q, pace_d;

    logic          req_rise, we, consume;
    logic [AW-1:0] wptr, wnext;
    logic [AW:0]   free_raw, free;
    logic          empty;

    assign empty    = (out_first_q == out_last_q);
    assign req_rise = bus.out_req_i & ~req_q;
    assign consume  = bus.app_out_valid_o & bus.app_out_ready_i;

    always_comb begin
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        ovf_d       = ovf_q;
        req_d       = bus.out_req_i;
        pace_d      = pace_q;
        we          = 1'b0;
        // A packet start rebases the tentative pointer even if a byte lands in the same cycle.
        wptr        = req_rise ? out_last_q : out_last_qq;
        wnext       = wptr;
        if (req_rise) ovf_d = 1'b0;
        if (bus.out_valid_i) begin
            if (inc(wptr) == out_first_q) begin
                ovf_d = 1'b1;
            end else begin
                we    = 1'b1;
                wnext = inc(wptr);
            end
        end
        out_last_qd = wnext;
        if (bus.out_err_i) begin
            out_last_qd = out_last_q;
        end else if (bus.out_ready_i) begin
            if (ovf_d) out_last_qd = out_last_q;
            else       out_last_d  = wnext;
        end
        if (consume) begin
            out_first_d = inc(out_first_q);
            pace_d      = '0;
        end else if (pace_q != PACE_MAX) begin
            pace_d = pace_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_first_q <= '0;
            out_last_q  <= '0;
            out_last_qq <= '0;
            ovf_q       <= 1'b0;
            req_q       <= 1'b0;
            pace_q      <= '0;
        end else begin
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_last_qq <= out_last_qd;
            ovf_q       <= ovf_d;
            req_q       <= req_d;
            pace_q      <= pace_d;
        end
    end

    out_fifo_mem #(.DEPTH(OUT_LENGTH), .AW(AW)) u_mem (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .we_i    (we),
        .waddr_i (wptr),
        .wdata_i (bus.out_data_i),
        .raddr_i (out_first_q),
        .rdata_o (bus.app_out_data_o)
    );

    // Offset by OUT_LENGTH-1 before subtracting so the free count never goes negative.
    assign free_raw = {1'b0, out_first_q} + (AW+1)'(OUT_LENGTH - 1) - {1'b0, out_last_q};
    assign free     = (free_raw >= (AW+1)'(OUT_LENGTH)) ? free_raw - (AW+1)'(OUT_LENGTH) : free_raw;

    assign bus.out_empty_o     = empty;
    assign bus.out_full_o      = (inc(out_last_qq) == out_first_q);
    assign bus.out_nak_o       = (free < (AW+1)'(OUT_MAXPACKETSIZE));
    assign bus.app_out_valid_o = ~empty & (pace_q == PACE_MAX);
endmodule

// File: tb/tb_out_fifo.sv
// Bench for out_fifo: directed scenarios plus random packets, checked every cycle against a
// queue-based model of committed and tentative bytes.
module tb_out_fifo;
    localparam int MPS = 8;
    localparam int BS  = 4;
    localparam int CAP = 2 * MPS;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    out_fifo_if ifc ();

    out_fifo #(.OUT_MAXPACKETSIZE(MPS), .BIT_SAMPLES(BS)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (ifc)
    );

    int n_chk  = 0;
    int n_pass = 0;
    byte unsigned comm_q[$];
    byte unsigned tent_q[$];
    byte unsigned rec_q[$];
    byte unsigned exp_q[$];
    bit  m_ovf, m_req;
    int  m_pace;
    int  rd_mode = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Model: committed bytes, tentative bytes, drop flag, cycles since the last consume.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            comm_q.delete();
            tent_q.delete();
            m_ovf  = 1'b0;
            m_req  = 1'b0;
            m_pace = 0;
        end else begin
            bit consume;
            consume = (comm_q.size() > 0) && (m_pace == BS - 1) && ifc.app_out_ready_i;
            if (ifc.out_req_i && !m_req) begin
                tent_q.delete();
                m_ovf = 1'b0;
            end
            m_req = ifc.out_req_i;
            if (ifc.out_valid_i) begin
                if (comm_q.size() + tent_q.size() == CAP) m_ovf = 1'b1;
                else tent_q.push_back(ifc.out_data_i);
            end
            if (ifc.out_err_i) begin
                tent_q.delete();
            end else if (ifc.out_ready_i) begin
                if (!m_ovf) foreach (tent_q[i]) comm_q.push_back(tent_q[i]);
                tent_q.delete();
            end
            if (consume) begin
                void'(comm_q.pop_front());
                m_pace = 0;
            end else if (m_pace < BS - 1) begin
                m_pace++;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            bit m_valid;
            m_valid = (comm_q.size() > 0) && (m_pace == BS - 1);
            chk("empty", int'(ifc.out_empty_o), int'(comm_q.size() == 0));
            chk("full",  int'(ifc.out_full_o),  int'(comm_q.size() + tent_q.size() == CAP));
            chk("nak",   int'(ifc.out_nak_o),   int'((CAP - comm_q.size()) < MPS));
            chk("valid", int'(ifc.app_out_valid_o), int'(m_valid));
            if (m_valid) chk("data", int'(ifc.app_out_data_o), int'(comm_q[0]));
            if (ifc.app_out_valid_o && ifc.app_out_ready_i) rec_q.push_back(ifc.app_out_data_o);
        end
    end

    always @(posedge clk) begin
        #2;
        case (rd_mode)
            0:       ifc.app_out_ready_i = 1'b0;
            1:       ifc.app_out_ready_i = 1'b1;
            default: ifc.app_out_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fate: 0 commit after, 1 error after, 2 abort, 3 commit with last byte, 4 error+commit with last byte
    task automatic pkt(input int n, input int fate, input int base, input bit rnd, input int gapmax);
        ifc.out_req_i = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            ifc.out_data_i  = rnd ? 8'($urandom) : 8'(base + i);
            ifc.out_valid_i = 1'b1;
            if (i == n - 1 && (fate == 3 || fate == 4)) ifc.out_ready_i = 1'b1;
            if (i == n - 1 && fate == 4) ifc.out_err_i = 1'b1;
            tick();
            ifc.out_valid_i = 1'b0;
            ifc.out_ready_i = 1'b0;
            ifc.out_err_i   = 1'b0;
            repeat ($urandom_range(0, gapmax)) tick();
        end
        if (fate == 0 || ((fate == 3 || fate == 4) && n == 0)) ifc.out_ready_i = 1'b1;
        if (fate == 1 || (fate == 4 && n == 0)) ifc.out_err_i = 1'b1;
        if (fate != 2 && !((fate == 3 || fate == 4) && n > 0)) tick();
        ifc.out_ready_i = 1'b0;
        ifc.out_err_i   = 1'b0;
        ifc.out_req_i   = 1'b0;
        tick();
    endtask

    task automatic drain();
        int cnt = 0;
        rd_mode = 1;
        while (comm_q.size() > 0 && cnt < 500) begin
            tick();
            cnt++;
        end
        chk("drain_done", comm_q.size(), 0);
        rd_mode = 0;
        tick();
        tick();
    endtask

    task automatic chk_rec(input string nm);
        chk({nm, "_len"}, rec_q.size(), exp_q.size());
        for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) chk(nm, int'(rec_q[i]), int'(exp_q[i]));
        rec_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int cnt;
        ifc.out_req_i   = 1'b0;
        ifc.out_data_i  = 8'h00;
        ifc.out_valid_i = 1'b0;
        ifc.out_ready_i = 1'b0;
        ifc.out_err_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", int'(ifc.out_empty_o), 1);
        chk("rst_valid", int'(ifc.app_out_valid_o), 0);
        chk("rst_data",  int'(ifc.app_out_data_o), 0);
        chk("rst_full",  int'(ifc.out_full_o), 0);
        chk("rst_nak",   int'(ifc.out_nak_o), 0);
        rstn = 1'b1;
        tick();

        chk("basic_empty_pre", int'(ifc.out_empty_o), 1);
        pkt(8, 0, 8'h01, 1'b0, 2);
        chk("basic_empty_post", int'(ifc.out_empty_o), 0);
        drain();
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        chk_rec("basic_rd");
        chk("basic_empty_end", int'(ifc.out_empty_o), 1);

        pkt(5, 1, 8'h30, 1'b0, 1);
        chk("rb_empty", int'(ifc.out_empty_o), 1);
        pkt(3, 0, 8'hA0, 1'b0, 1);
        drain();
        exp_q = '{8'hA0, 8'hA1, 8'hA2};
        chk_rec("rb_rd");

        pkt(8, 0, 8'h10, 1'b0, 0);
        chk("nak_free8", int'(ifc.out_nak_o), 0);
        chk("nak_model8", CAP - comm_q.size(), 8);
        pkt(1, 0, 8'h18, 1'b0, 0);
        chk("nak_free7", int'(ifc.out_nak_o), 1);
        rd_mode = 1;
        cnt = 0;
        while (rec_q.size() == 0 && cnt < 50) begin
            tick();
            cnt++;
        end
        rd_mode = 0;
        tick();
        chk("nak_after_read", int'(ifc.out_nak_o), 0);
        drain();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h10 + i));
        chk_rec("nak_rd");

        pkt(8, 0, 8'h40, 1'b0, 0);
        pkt(2, 0, 8'h48, 1'b0, 0);
        pkt(8, 0, 8'h60, 1'b0, 0);
        chk("ovf_model10", comm_q.size(), 10);
        chk("ovf_full", int'(ifc.out_full_o), 0);
        chk("ovf_nak", int'(ifc.out_nak_o), 1);
        drain();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h40 + i));
        chk_rec("ovf_rd");

        for (int k = 0; k < 4; k++) begin
            pkt(8, 0, 0, 1'b1, 1);
            drain();
        end
        rec_q.delete();

        pkt(4, 2, 8'h70, 1'b0, 0);
        pkt(2, 0, 8'h55, 1'b0, 0);
        drain();
        exp_q = '{8'h55, 8'h56};
        chk_rec("abort_rd");

        rd_mode = 2;
        repeat (60) pkt($urandom_range(0, MPS), $urandom_range(0, 4), 0, 1'b1, 3);
        drain();
        rec_q.delete();

        pkt(3, 0, 8'h80, 1'b0, 0);
        chk("mid_empty_pre", int'(ifc.out_empty_o), 0);
        ifc.out_req_i = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            ifc.out_data_i  = 8'(8'h90 + i);
            ifc.out_valid_i = 1'b1;
            tick();
            ifc.out_valid_i = 1'b0;
        end
        #3;
        rstn = 1'b0;
        #1;
        chk("mid_rst_empty", int'(ifc.out_empty_o), 1);
        chk("mid_rst_valid", int'(ifc.app_out_valid_o), 0);
        chk("mid_rst_nak",   int'(ifc.out_nak_o), 0);
        chk("mid_rst_full",  int'(ifc.out_full_o), 0);
        ifc.out_req_i = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_empty", int'(ifc.out_empty_o), 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: run did not complete, %0d of %0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule
